// File: rtl/sort_arb_pkg.sv
// ---------------------------------------------------------------------------
// sort_arb_pkg
// Shared definitions for the packet arbiter in front of the main_sort engine.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED, DRAIN)
//   chan_w()    : width of a port index, never less than one bit
//   STAT_W      : width of the optional statistics counters
// ---------------------------------------------------------------------------
package sort_arb_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    // A two-port arbiter still needs one bit of channel index.
    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sort_pkt_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search: returns the first asserted request
// at or above ptr, wrapping past the top port back to port 0.
//   req   : one request bit per port
//   ptr   : port with highest priority this cycle
//   found : at least one request is asserted
//   idx   : winning port index (only meaningful when found is high)
// ---------------------------------------------------------------------------
module rr_picker
    import sort_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int CHAN_W    = chan_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [CHAN_W-1:0]    ptr,
    output logic                 found,
    output logic [CHAN_W-1:0]    idx
);

    localparam logic [CHAN_W:0] NP = (CHAN_W+1)'(NUM_PORTS);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [CHAN_W-1:0]      offset;
    logic [CHAN_W:0]        sum;

    // Doubling the request vector turns the wrap-around search into a plain
    // shift: after shifting by ptr, bit k of the low half is port ptr+k
    // modulo NUM_PORTS. A lowest-set-bit search then gives the offset from ptr.
    always_comb begin
        req_dbl = {req, req};
        req_rot = NUM_PORTS'(req_dbl >> ptr);
        found   = 1'b0;
        offset  = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = CHAN_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= NP) begin
            sum = sum - NP;
        end
        idx = sum[CHAN_W-1:0];
    end

endmodule

// File: rtl/sort_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// sort_pkt_arbiter
// Packet-level round-robin arbiter that shares one main_sort engine between
// NUM_PORTS Avalon-ST producers (ready latency 0). A port is granted for a
// whole packet; packets longer than MAX_PKT_LEN are cut with a forced EOP and
// their remainder is drained. One bubble cycle is spent arbitrating per packet.
//
// Ports:
//   clk_i, srst_i        : clock, synchronous active-high reset
//   snk_*_i / snk_ready_o: per-port Avalon-ST sinks (data packed per port)
//   src_*_o / src_ready_i: Avalon-ST source towards the sorter
//   src_chan_o           : index of the granted port, valid with src_valid_o
//   trunc_o              : one-cycle pulse on the beat that truncates a packet
//
// Optional feature, macro SORT_ARB_STATS_EN: adds pkt_cnt_o (per-port granted
// packet counters) and trunc_cnt_o (truncation counter), both saturating.
// ---------------------------------------------------------------------------
module sort_pkt_arbiter
    import sort_arb_pkg::*;
#(
    parameter  int DWIDTH      = 8,
    parameter  int NUM_PORTS   = 4,
    parameter  int MAX_PKT_LEN = 16,
    localparam int CHAN_W      = chan_w(NUM_PORTS)
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic [NUM_PORTS-1:0][DWIDTH-1:0]  snk_data_i,
    input  logic [NUM_PORTS-1:0]              snk_startofpacket_i,
    input  logic [NUM_PORTS-1:0]              snk_endofpacket_i,
    input  logic [NUM_PORTS-1:0]              snk_valid_i,
    output logic [NUM_PORTS-1:0]              snk_ready_o,
    output logic [DWIDTH-1:0]                 src_data_o,
    output logic                              src_startofpacket_o,
    output logic                              src_endofpacket_o,
    output logic                              src_valid_o,
    input  logic                              src_ready_i,
    output logic [CHAN_W-1:0]                 src_chan_o,
    output logic                              trunc_o
`ifdef SORT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]                 pkt_cnt_o [NUM_PORTS],
    output logic [STAT_W-1:0]                 trunc_cnt_o
`endif
);

    localparam int                CNT_W     = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [CHAN_W-1:0] LAST_PORT = CHAN_W'(NUM_PORTS - 1);

    arb_state_t           state, state_nxt;
    logic [CHAN_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CHAN_W-1:0]    grant, grant_nxt;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;

    logic [NUM_PORTS-1:0] cand;
    logic                 pick_found;
    logic [CHAN_W-1:0]    pick_idx;

    logic                 sel_valid;
    logic                 sel_eop;
    logic [DWIDTH-1:0]    sel_data;
    logic                 xfer;
    logic                 at_limit;

    // Only a valid beat carrying SOP may open a packet.
    assign cand = snk_valid_i & snk_startofpacket_i;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req   (cand),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sel_valid = snk_valid_i[grant];
    assign sel_eop   = snk_endofpacket_i[grant];
    assign sel_data  = snk_data_i[grant];
    assign xfer      = (state == LOCKED) && sel_valid && src_ready_i;
    assign at_limit  = (beat_cnt == LAST_BEAT);

    // State register: FSM state, round-robin pointer, grant and beat counter.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state logic. The grant is registered in IDLE, so the first beat of
    // a packet moves in the following cycle. Hitting the length limit without
    // EOP sends the FSM to DRAIN to swallow the rest of the packet.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = LOCKED;
                    grant_nxt    = pick_idx;
                    rr_ptr_nxt   = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
                    beat_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (sel_eop) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                    end else if (at_limit) begin
                        state_nxt    = DRAIN;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (sel_valid && sel_eop) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic. In IDLE, non-SOP beats are junk and are accepted so they
    // cannot block a port forever; SOP beats are held until granted. While
    // LOCKED the granted port is a straight combinational path to the sorter.
    always_comb begin
        snk_ready_o         = '0;
        src_valid_o         = 1'b0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;
        src_data_o          = '0;
        trunc_o             = 1'b0;
        src_chan_o          = grant;
        unique case (state)
            IDLE: begin
                snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
            end
            LOCKED: begin
                snk_ready_o[grant]  = src_ready_i;
                src_valid_o         = sel_valid;
                src_data_o          = sel_data;
                src_startofpacket_o = sel_valid && (beat_cnt == '0);
                src_endofpacket_o   = sel_valid && (sel_eop || at_limit);
                trunc_o             = xfer && !sel_eop && at_limit;
            end
            DRAIN: begin
                snk_ready_o[grant] = 1'b1;
            end
            default: begin
                snk_ready_o = '0;
            end
        endcase
    end

`ifdef SORT_ARB_STATS_EN
    logic grant_evt;

    assign grant_evt = (state == IDLE) && pick_found;

    // Saturating statistics: packets granted per port and truncations seen.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_o[i] <= '0;
            end
            trunc_cnt_o <= '0;
        end else begin
            if (grant_evt && (pkt_cnt_o[pick_idx] != '1)) begin
                pkt_cnt_o[pick_idx] <= pkt_cnt_o[pick_idx] + 1'b1;
            end
            if (trunc_o && (trunc_cnt_o != '1)) begin
                trunc_cnt_o <= trunc_cnt_o + 1'b1;
            end
        end
    end
`else
    // Statistics disabled: no counters and no extra ports are built.
`endif

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sort_pkt_arbiter
// Self-checking bench for sort_pkt_arbiter (default build, stats disabled).
// Packets are described in a vector table; each burst is loaded into per-port
// producer queues while the expected sorter-side beats go into a scoreboard.
// ---------------------------------------------------------------------------
module tb_sort_pkt_arbiter;

    localparam int DWIDTH      = 8;
    localparam int NUM_PORTS   = 4;
    localparam int MAX_PKT_LEN = 16;
    localparam int CHAN_W      = 2;
    localparam int BUDGET      = 2000;
    localparam int NVEC        = 15;
    localparam int NBURST      = 7;

    logic                             clk_i = 1'b0;
    logic                             srst_i;
    logic [NUM_PORTS-1:0][DWIDTH-1:0] snk_data_i;
    logic [NUM_PORTS-1:0]             snk_startofpacket_i;
    logic [NUM_PORTS-1:0]             snk_endofpacket_i;
    logic [NUM_PORTS-1:0]             snk_valid_i;
    logic [NUM_PORTS-1:0]             snk_ready_o;
    logic [DWIDTH-1:0]                src_data_o;
    logic                             src_startofpacket_o;
    logic                             src_endofpacket_o;
    logic                             src_valid_o;
    logic                             src_ready_i;
    logic [CHAN_W-1:0]                src_chan_o;
    logic                             trunc_o;

    typedef struct {
        logic [DWIDTH-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    typedef struct {
        logic [CHAN_W-1:0] chan;
        logic [DWIDTH-1:0] data;
        logic              sop;
        logic              eop;
    } out_t;

    typedef struct {
        int burst;
        int port;
        int len;
        int base;
        int junk;
        int exp_fwd;
        int exp_trunc;
        bit gap;
        bit throttle;
    } vec_t;

    beat_t port_q [NUM_PORTS][$];
    out_t  sb_q[$];
    vec_t  vecs [NVEC];

    int tests;
    int fails;
    int exp_trunc_cnt;
    int trunc_seen;
    int cyc;
    int last_eop;

    always #5 clk_i = ~clk_i;

    sort_pkt_arbiter #(
        .DWIDTH      (DWIDTH),
        .NUM_PORTS   (NUM_PORTS),
        .MAX_PKT_LEN (MAX_PKT_LEN)
    ) dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .snk_data_i          (snk_data_i),
        .snk_startofpacket_i (snk_startofpacket_i),
        .snk_endofpacket_i   (snk_endofpacket_i),
        .snk_valid_i         (snk_valid_i),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_startofpacket_o),
        .src_endofpacket_o   (src_endofpacket_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready_i),
        .src_chan_o          (src_chan_o),
        .trunc_o             (trunc_o)
    );

    task automatic idleInputs();
        snk_valid_i         = '0;
        snk_startofpacket_i = '0;
        snk_endofpacket_i   = '0;
        snk_data_i          = '0;
        src_ready_i         = 1'b1;
    endtask

    task automatic resetDut();
        idleInputs();
        srst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        srst_i = 1'b0;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue one packet on a port (optionally preceded by junk beats) and
    // record the beats the sorter should see, with EOP forced at the limit.
    task automatic loadPacket(input int port, input int len, input int base,
                              input int junk, input int exp_fwd);
        beat_t bt;
        out_t  ot;
        for (int j = 0; j < junk; j++) begin
            bt.data = 8'hEE;
            bt.sop  = 1'b0;
            bt.eop  = 1'b0;
            port_q[port].push_back(bt);
        end
        for (int b = 0; b < len; b++) begin
            bt.data = DWIDTH'(base + b);
            bt.sop  = (b == 0);
            bt.eop  = (b == len - 1);
            port_q[port].push_back(bt);
            if (b < exp_fwd) begin
                ot.chan = CHAN_W'(port);
                ot.data = DWIDTH'(base + b);
                ot.sop  = (b == 0);
                ot.eop  = (b == len - 1) || (b == exp_fwd - 1);
                sb_q.push_back(ot);
            end
        end
    endtask

    // Compare a transferred sorter beat against the scoreboard; optionally
    // require exactly one bubble cycle between an EOP and the next SOP.
    task automatic checkOutput(input bit gap_chk);
        out_t ex;
        if (trunc_o) trunc_seen++;
        if (src_valid_o && src_ready_i) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL extra_beat: got chan=%0d data=%h, expected no beat",
                         src_chan_o, src_data_o);
            end else begin
                ex = sb_q.pop_front();
                if (src_chan_o !== ex.chan || src_data_o !== ex.data ||
                    src_startofpacket_o !== ex.sop || src_endofpacket_o !== ex.eop) begin
                    fails++;
                    $display("[TB] FAIL beat: got chan=%0d data=%h sop=%b eop=%b, expected chan=%0d data=%h sop=%b eop=%b",
                             src_chan_o, src_data_o, src_startofpacket_o, src_endofpacket_o,
                             ex.chan, ex.data, ex.sop, ex.eop);
                end
            end
            if (gap_chk && src_startofpacket_o) begin
                tests++;
                if (cyc != last_eop + 2) begin
                    fails++;
                    $display("[TB] FAIL bubble: got SOP at cycle %0d, expected cycle %0d",
                             cyc, last_eop + 2);
                end
            end
            if (src_endofpacket_o) last_eop = cyc;
        end
    endtask

    // Drive all producer queues and monitor the sorter side until both the
    // producers and the scoreboard are empty, or the cycle budget runs out.
    task automatic applyStimulus(input bit gap_chk, input bit throttle);
        bit busy;
        cyc      = 0;
        last_eop = -1;
        while (cyc < BUDGET) begin
            busy = (sb_q.size() != 0);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_q[p].size() != 0) busy = 1'b1;
            end
            if (!busy) break;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_q[p].size() != 0) begin
                    snk_valid_i[p]         = 1'b1;
                    snk_data_i[p]          = port_q[p][0].data;
                    snk_startofpacket_i[p] = port_q[p][0].sop;
                    snk_endofpacket_i[p]   = port_q[p][0].eop;
                end else begin
                    snk_valid_i[p]         = 1'b0;
                    snk_data_i[p]          = '0;
                    snk_startofpacket_i[p] = 1'b0;
                    snk_endofpacket_i[p]   = 1'b0;
                end
            end
            src_ready_i = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            checkOutput(gap_chk);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (snk_valid_i[p] && snk_ready_o[p]) void'(port_q[p].pop_front());
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        if (cyc >= BUDGET) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: got %0d beats still expected after %0d cycles, expected 0",
                     sb_q.size(), BUDGET);
            sb_q.delete();
            for (int p = 0; p < NUM_PORTS; p++) port_q[p].delete();
        end
        idleInputs();
    endtask

    task automatic checkBurstEnd(input int burst);
        tests++;
        if (trunc_seen != exp_trunc_cnt) begin
            fails++;
            $display("[TB] FAIL trunc_count burst %0d: got %0d pulses, expected %0d",
                     burst, trunc_seen, exp_trunc_cnt);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //            burst port len base junk fwd trunc gap thr
        vecs[0]  = '{0, 0,  2, 'h10, 0,  2, 0, 1'b1, 1'b0};
        vecs[1]  = '{0, 2,  2, 'h20, 0,  2, 0, 1'b1, 1'b0};
        vecs[2]  = '{1, 0,  3, 'h40, 0,  3, 0, 1'b1, 1'b0};
        vecs[3]  = '{1, 1,  3, 'h50, 0,  3, 0, 1'b1, 1'b0};
        vecs[4]  = '{1, 2,  3, 'h60, 0,  3, 0, 1'b1, 1'b0};
        vecs[5]  = '{1, 3,  3, 'h70, 0,  3, 0, 1'b1, 1'b0};
        vecs[6]  = '{1, 0,  3, 'h48, 0,  3, 0, 1'b1, 1'b0};
        vecs[7]  = '{2, 1, 20, 'h80, 0, 16, 1, 1'b0, 1'b0};
        vecs[8]  = '{2, 1,  2, 'hC8, 0,  2, 0, 1'b0, 1'b0};
        vecs[9]  = '{3, 0,  5, 'h30, 0,  5, 0, 1'b0, 1'b1};
        vecs[10] = '{3, 1,  5, 'h38, 0,  5, 0, 1'b0, 1'b1};
        vecs[11] = '{3, 2,  5, 'h58, 0,  5, 0, 1'b0, 1'b1};
        vecs[12] = '{4, 3,  1, 'hA0, 2,  1, 0, 1'b0, 1'b0};
        vecs[13] = '{5, 2, 16, 'h60, 0, 16, 0, 1'b1, 1'b0};
        vecs[14] = '{6, 0, 17, 'h01, 0, 16, 1, 1'b0, 1'b0};

        // Reset state with quiet inputs: every output low.
        resetDut();
        @(negedge clk_i);
        checkVal("reset_state", 32'({src_valid_o, src_startofpacket_o, src_endofpacket_o,
                                     trunc_o, snk_ready_o, src_chan_o, src_data_o}), 32'h0);
        @(posedge clk_i);
        #1;

        // Table-driven bursts, each starting from reset so rr_ptr begins at 0.
        for (int b = 0; b < NBURST; b++) begin
            bit gap;
            bit thr;
            resetDut();
            gap           = 1'b0;
            thr           = 1'b0;
            trunc_seen    = 0;
            exp_trunc_cnt = 0;
            for (int i = 0; i < NVEC; i++) begin
                if (vecs[i].burst == b) begin
                    loadPacket(vecs[i].port, vecs[i].len, vecs[i].base,
                               vecs[i].junk, vecs[i].exp_fwd);
                    exp_trunc_cnt += vecs[i].exp_trunc;
                    gap = vecs[i].gap;
                    thr = vecs[i].throttle;
                end
            end
            applyStimulus(gap, thr);
            checkBurstEnd(b);
        end

        // Reset in the middle of a packet on port 1, during its 4th beat.
        resetDut();
        snk_valid_i[1]         = 1'b1;
        snk_startofpacket_i[1] = 1'b1;
        snk_data_i[1]          = 8'hC0;
        @(negedge clk_i);
        checkVal("rst_bubble", 32'({src_valid_o, snk_ready_o}), 32'h0);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [DWIDTH-1:0] d;
            d                      = DWIDTH'(8'hC0 + k);
            snk_startofpacket_i[1] = (k == 0);
            snk_data_i[1]          = d;
            @(negedge clk_i);
            checkVal("rst_beat", 32'({src_valid_o, src_startofpacket_o, src_chan_o, src_data_o}),
                     32'({1'b1, (k == 0), 2'd1, d}));
            @(posedge clk_i);
            #1;
        end
        snk_startofpacket_i[1] = 1'b0;
        snk_data_i[1]          = 8'hC3;
        srst_i                 = 1'b1;
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        idleInputs();
        @(negedge clk_i);
        checkVal("rst_outputs", 32'({src_valid_o, src_startofpacket_o, src_endofpacket_o,
                                     trunc_o, snk_ready_o, src_chan_o, src_data_o}), 32'h0);
        @(posedge clk_i);
        #1;
        // With rr_ptr back at 0, port 1 must beat port 3.
        trunc_seen    = 0;
        exp_trunc_cnt = 0;
        loadPacket(1, 2, 'hD0, 0, 2);
        loadPacket(3, 2, 'hE0, 0, 2);
        applyStimulus(1'b1, 1'b0);
        checkBurstEnd(NBURST);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
